// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: active-low
// segment patterns ({a,b,c,d,e,f,g}) and active-low digit enables.
package ssd_pkg;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Index 0 is the rightmost digit.
  localparam logic [3:0] DIGIT_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/ssd_scan_ctl_if.sv
// Display bus: BCD digits and controls in from the counter chain,
// multiplexed common-anode drive out to the board.
interface ssd_scan_ctl_if;

  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_seg;

  modport master (
    output bcd0, bcd1, bcd2, bcd3, dp_in, blank_lz,
    input  ssd_ctl, ssd_seg
  );

  modport slave (
    input  bcd0, bcd1, bcd2, bcd3, dp_in, blank_lz,
    output ssd_ctl, ssd_seg
  );

endinterface

// File: rtl/bcd_to_ssd.sv
// BCD to active-low seven-segment decoder. Codes 10..15 show a dash so an
// invalid digit is visible on the board instead of propagating X.
module bcd_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; default covers every non-BCD code.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctl.sv
// Four-digit multiplexed seven-segment scan controller. A free-running
// refresh counter selects the digit; inputs are captured once per frame so
// a frame never mixes old and new values; outputs are registered.
module ssd_scan_ctl
  import ssd_pkg::*;
#(
  parameter int SCAN_CNT_W = 17,
  parameter int LZ_EN      = 1
) (
  input  logic           clk,
  input  logic           rst,
  ssd_scan_ctl_if.slave  bus
);

  logic [SCAN_CNT_W-1:0] scan_cnt;
  logic [1:0]            idx;
  logic                  frame_end;

  logic [3:0][3:0]       sh_dig;
  logic [3:0]            sh_dp;
  logic                  sh_blank_lz;

  logic                  lz_on;
  logic [3:0]            blank;
  logic [3:0]            cur_dig;
  logic [6:0]            dec_seg;
  logic [7:0]            seg_nxt;

  logic [3:0]            ctl_q;
  logic [7:0]            seg_q;

  assign idx       = scan_cnt[SCAN_CNT_W-1 -: 2];
  assign frame_end = &scan_cnt;

  // Refresh counter, wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scan_cnt <= '0;
    else     scan_cnt <= scan_cnt + SCAN_CNT_W'(1);
  end

  // Capture the display inputs on the last cycle of a frame so the next
  // frame is shown from one consistent snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_dig      <= '0;
      sh_dp       <= '0;
      sh_blank_lz <= 1'b0;
    end else if (frame_end) begin
      sh_dig      <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
      sh_dp       <= bus.dp_in;
      sh_blank_lz <= bus.blank_lz;
    end
  end

  // Leading-zero chain from the left; digit 0 always shows so a value of
  // zero still displays "0".
  always_comb begin
    lz_on    = (LZ_EN != 0) && sh_blank_lz;
    blank    = '0;
    blank[3] = lz_on && (sh_dig[3] == 4'd0);
    blank[2] = blank[3] && (sh_dig[2] == 4'd0);
    blank[1] = blank[2] && (sh_dig[1] == 4'd0);
  end

  assign cur_dig = sh_dig[idx];

  bcd_to_ssd u_dec (
    .bcd (cur_dig),
    .seg (dec_seg)
  );

  // Segment word for the active slot; dp is independent of blanking.
  always_comb begin
    seg_nxt = {(blank[idx] ? SEG_OFF : dec_seg), ~sh_dp[idx]};
  end

  // Registered output stage, one cycle behind idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= 4'b1111;
      seg_q <= 8'hFF;
    end else begin
      ctl_q <= DIGIT_SEL[idx];
      seg_q <= seg_nxt;
    end
  end

  assign bus.ssd_ctl = ctl_q;
  assign bus.ssd_seg = seg_q;

endmodule
